// File: rtl/looper_pkg.sv
// Shared types and helpers for the multi-channel audio looper.
// Holds the looper state encoding and the per-channel saturating adder.
package looper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECORD  = 2'd1,
        ST_PLAY    = 2'd2,
        ST_OVERDUB = 2'd3
    } state_t;

    // Widest supported sample; callers sign-extend into and truncate out of this width.
    localparam int unsigned SAT_W = 32;

    // Signed add clamped to the range of a data_w-bit two's-complement sample.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             data_w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = $signed(((SAT_W+1)'(1) << (data_w - 1)) - (SAT_W+1)'(1));
        lo  = ~hi;
        if (sum > hi) begin
            return SAT_W'(hi);
        end else if (sum < lo) begin
            return SAT_W'(lo);
        end
        return SAT_W'(sum);
    endfunction

endpackage

// File: rtl/looper_ram.sv
// Single-port synchronous loop RAM, read-first, one-cycle read latency.
module looper_ram #(
    parameter int unsigned WIDTH  = 48,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/audio_looper_mc.sv
// Multi-channel audio looper: records a loop into RAM and plays it back mixed with live input.
// Define LOOPER_OVERDUB_EN to compile in the OVERDUB state and RAM write-back.
module audio_looper_mc
    import looper_pkg::*;
#(
    parameter int unsigned CH     = 2,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 rec_pulse,
    input  logic                 clear,
    input  logic                 reverse,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_valid,
    output logic [1:0]           state,
    output logic [ADDR_W:0]      loop_len,
    output logic                 full
);

    localparam int unsigned FRAME_W = CH * DATA_W;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

    state_t              state_q;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic                dir_q;
    logic                dir_nxt;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     len_nxt;
    logic [ADDR_W-1:0]   play_addr;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [FRAME_W-1:0]  ram_wdata;
    logic [FRAME_W-1:0]  ram_rdata;

    logic                v1_q;
    logic [FRAME_W-1:0]  in_q;
    state_t              mode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [FRAME_W-1:0]  mix;
    logic                wb_en;

    // One pointer step inside the recorded loop, wrapping at either end.
    function automatic logic [ADDR_W-1:0] step(
        input logic [ADDR_W-1:0] p,
        input logic              rev,
        input logic [ADDR_W:0]   len
    );
        logic [ADDR_W-1:0] last;
        last = ADDR_W'(len - (ADDR_W+1)'(1));
        if (rev) begin
            return (p == '0) ? last : p - ADDR_W'(1);
        end
        return (p == last) ? '0 : p + ADDR_W'(1);
    endfunction

    looper_ram #(
        .WIDTH  (FRAME_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Per-channel saturating mix of the captured live frame with the loop word.
    always_comb begin
        mix = '0;
        for (int c = 0; c < int'(CH); c++) begin
            mix[c*DATA_W +: DATA_W] = DATA_W'(sat_add(
                SAT_W'($signed(in_q[c*DATA_W +: DATA_W])),
                SAT_W'($signed(ram_rdata[c*DATA_W +: DATA_W])),
                DATA_W));
        end
    end

`ifdef LOOPER_OVERDUB_EN
    assign wb_en = v1_q && (mode_q == ST_OVERDUB) && !clear;
`else
    assign wb_en = 1'b0;
`endif

    // A direction flip first steps back to the last-played address, so playback never jumps.
    assign play_addr = (reverse == dir_q) ? ptr_q
                                          : step(step(ptr_q, reverse, len_q), reverse, len_q);

    // Next-state, pointer and RAM port control.
    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        dir_nxt   = dir_q;
        len_nxt   = len_q;
        ram_we    = 1'b0;
        ram_addr  = ptr_q;
        ram_wdata = in_data;

        if (clear) begin
            state_nxt = ST_IDLE;
            len_nxt   = '0;
            ptr_nxt   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rec_pulse) begin
                        state_nxt = ST_RECORD;
                        ptr_nxt   = '0;
                        len_nxt   = '0;
                    end
                end
                ST_RECORD: begin
                    if (sample_en) begin
                        ram_we  = 1'b1;
                        ptr_nxt = ptr_q + ADDR_W'(1);
                        len_nxt = len_q + (ADDR_W+1)'(1);
                    end
                    if ((sample_en && len_nxt == LEN_FULL) || (rec_pulse && len_nxt != '0)) begin
                        state_nxt = ST_PLAY;
                        dir_nxt   = reverse;
                        ptr_nxt   = reverse ? ADDR_W'(len_nxt - (ADDR_W+1)'(1)) : '0;
                    end else if (rec_pulse) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_PLAY, ST_OVERDUB: begin
                    if (sample_en) begin
                        ram_addr = play_addr;
                        ptr_nxt  = step(play_addr, reverse, len_q);
                        dir_nxt  = reverse;
                    end
`ifdef LOOPER_OVERDUB_EN
                    if (rec_pulse) begin
                        state_nxt = (state_q == ST_PLAY) ? ST_OVERDUB : ST_PLAY;
                    end
`endif
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        if (wb_en) begin
            ram_we    = 1'b1;
            ram_addr  = addr_q;
            ram_wdata = mix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Pointer, length and the two-stage output pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            dir_q     <= 1'b0;
            len_q     <= '0;
            full      <= 1'b0;
            v1_q      <= 1'b0;
            in_q      <= '0;
            mode_q    <= ST_IDLE;
            addr_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            ptr_q     <= ptr_nxt;
            dir_q     <= dir_nxt;
            len_q     <= len_nxt;
            full      <= (len_nxt == LEN_FULL);
            v1_q      <= sample_en && !clear;
            out_valid <= v1_q && !clear;
            if (sample_en) begin
                in_q   <= in_data;
                mode_q <= state_q;
                addr_q <= ram_addr;
            end
            if (v1_q && !clear) begin
                out_data <= (mode_q == ST_PLAY || mode_q == ST_OVERDUB) ? mix : in_q;
            end
        end
    end

    assign state    = state_q;
    assign loop_len = len_q;

endmodule

// File: tb/tb_audio_looper_mc.sv
// Self-checking bench for audio_looper_mc (CH=2, DATA_W=24, ADDR_W=4).
module tb_audio_looper_mc;

    localparam int unsigned CH     = 2;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned FW     = CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sample_en = 1'b0;
    logic [FW-1:0]     in_data = '0;
    logic              rec_pulse = 1'b0;
    logic              clear = 1'b0;
    logic              reverse = 1'b0;
    logic [FW-1:0]     out_data;
    logic              out_valid;
    logic [1:0]        state;
    logic [ADDR_W:0]   loop_len;
    logic              full;

    int     n_pass  = 0;
    int     n_total = 0;
    longint cyc     = 0;

    logic [FW-1:0] exp_q[$];
    longint        exp_cyc_q[$];

    audio_looper_mc #(.CH(CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .in_data   (in_data),
        .rec_pulse (rec_pulse),
        .clear     (clear),
        .reverse   (reverse),
        .out_data  (out_data),
        .out_valid (out_valid),
        .state     (state),
        .loop_len  (loop_len),
        .full      (full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [FW-1:0] fr(input int ch0, input int ch1);
        return {24'(ch1), 24'(ch0)};
    endfunction

    function automatic logic [FW-1:0] frame_k(input int k);
        return fr(k + 16, -(k + 16));
    endfunction

    // Scoreboard: every output frame is popped and compared with the value and cycle pushed at its strobe.
    always @(negedge clk) begin
        logic [FW-1:0] e;
        longint        ec;
        if (!reset && out_valid) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_out: out_valid=1 with nothing pending, out_data=%h", out_data);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (out_data !== e || cyc != ec)
                    $display("FAIL frame_out: got %h at cycle %0d, want %h at cycle %0d", out_data, cyc, e, ec);
                else
                    n_pass++;
            end
        end
    end

    task automatic drive_frame(input logic [FW-1:0] d, input logic rp, input logic [FW-1:0] e);
        @(negedge clk);
        in_data   = d;
        sample_en = 1'b1;
        rec_pulse = rp;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 2);
        @(negedge clk);
        sample_en = 1'b0;
        rec_pulse = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rec();
        @(negedge clk);
        rec_pulse = 1'b1;
        @(negedge clk);
        rec_pulse = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (state !== 2'd0 || loop_len !== '0 || full !== 1'b0 || out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL reset_state: state=%0d len=%0d full=%b valid=%b data=%h, want all zero",
                     state, loop_len, full, out_valid, out_data);
        else
            n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        drive_frame(fr(123, -7), 1'b0, fr(123, -7));
        drive_frame(fr(-1, 4096), 1'b0, fr(-1, 4096));
        n_total++;
        if (state !== 2'd0) $display("FAIL idle_state: state=%0d want 0", state); else n_pass++;
    endtask

    task automatic test_reset_midrecord();
        pulse_rec();
        n_total++;
        if (state !== 2'd1) $display("FAIL rec_enter: state=%0d want 1", state); else n_pass++;
        for (int k = 1; k <= 5; k++) drive_frame(fr(k, k), 1'b0, fr(k, k));
        n_total++;
        if (loop_len !== 5'd5) $display("FAIL rec_len5: loop_len=%0d want 5", loop_len); else n_pass++;
        @(negedge clk);
        in_data   = fr(6, 6);
        sample_en = 1'b1;
        @(posedge clk);
        #2;
        sample_en = 1'b0;
        reset     = 1'b1;
        #1;
        n_total++;
        if (state !== 2'd0 || loop_len !== '0 || out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL reset_midrec: state=%0d len=%0d valid=%b data=%h, want all zero",
                     state, loop_len, out_valid, out_data);
        else
            n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_record_play();
        pulse_rec();
        for (int k = 1; k <= 6; k++) drive_frame(fr(k, -k), 1'b0, fr(k, -k));
        n_total++;
        if (loop_len !== 5'd6) $display("FAIL rp_len: loop_len=%0d want 6", loop_len); else n_pass++;
        pulse_rec();
        n_total++;
        if (state !== 2'd2) $display("FAIL rp_play: state=%0d want 2", state); else n_pass++;
        for (int i = 0; i < 8; i++) drive_frame('0, 1'b0, fr((i % 6) + 1, -((i % 6) + 1)));
    endtask

    task automatic test_reverse();
        int seq[7] = '{1, 2, 3, 2, 1, 6, 5};
        pulse_clear();
        n_total++;
        if (state !== 2'd0 || loop_len !== '0)
            $display("FAIL clear_state: state=%0d len=%0d want 0 0", state, loop_len);
        else
            n_pass++;
        // rec_pulse coincident with a strobe: frame passes through, recording starts after it
        drive_frame(fr(99, 99), 1'b1, fr(99, 99));
        for (int k = 1; k <= 6; k++) drive_frame(fr(k, 2 * k), (k == 6), fr(k, 2 * k));
        n_total++;
        if (state !== 2'd2 || loop_len !== 5'd6)
            $display("FAIL rev_setup: state=%0d len=%0d want 2 6", state, loop_len);
        else
            n_pass++;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) reverse = 1'b1;
            drive_frame('0, 1'b0, fr(seq[i], 2 * seq[i]));
        end
        reverse = 1'b0;
    endtask

    task automatic test_full();
        pulse_clear();
        pulse_rec();
        for (int k = 0; k < 15; k++) drive_frame(frame_k(k), 1'b0, frame_k(k));
        n_total++;
        if (state !== 2'd1 || full !== 1'b0 || loop_len !== 5'd15)
            $display("FAIL full_pre: state=%0d full=%b len=%0d want 1 0 15", state, full, loop_len);
        else
            n_pass++;
        drive_frame(frame_k(15), 1'b0, frame_k(15));
        n_total++;
        if (state !== 2'd2 || full !== 1'b1 || loop_len !== 5'd16)
            $display("FAIL full_hit: state=%0d full=%b len=%0d want 2 1 16", state, full, loop_len);
        else
            n_pass++;
        drive_frame(fr(1, 1), 1'b0, fr(17, -15));
        for (int k = 1; k < 16; k++) drive_frame('0, 1'b0, frame_k(k));
        drive_frame('0, 1'b0, frame_k(0));
    endtask

    task automatic test_saturation();
        pulse_clear();
        pulse_rec();
        drive_frame({24'h800010, 24'h7FFFF0}, 1'b0, {24'h800010, 24'h7FFFF0});
        drive_frame({24'h000005, 24'h000003}, 1'b1, {24'h000005, 24'h000003});
        drive_frame({24'hFFFF00, 24'h000100}, 1'b0, {24'h800000, 24'h7FFFFF});
        drive_frame({24'h000010, 24'hFFFFFE}, 1'b0, {24'h000015, 24'h000001});
    endtask

    task automatic test_overdub();
        pulse_clear();
        pulse_rec();
        drive_frame(fr(10, 10), 1'b0, fr(10, 10));
        drive_frame(fr(20, 20), 1'b1, fr(20, 20));
        pulse_rec();
        n_total++;
`ifdef LOOPER_OVERDUB_EN
        if (state !== 2'd3) $display("FAIL od_enter: state=%0d want 3", state); else n_pass++;
`else
        if (state !== 2'd2) $display("FAIL od_ignored: state=%0d want 2", state); else n_pass++;
`endif
        drive_frame(fr(5, 5), 1'b0, fr(15, 15));
        drive_frame(fr(5, 5), 1'b0, fr(25, 25));
`ifdef LOOPER_OVERDUB_EN
        pulse_rec();
`endif
        n_total++;
        if (state !== 2'd2) $display("FAIL od_exit: state=%0d want 2", state); else n_pass++;
`ifdef LOOPER_OVERDUB_EN
        drive_frame('0, 1'b0, fr(15, 15));
        drive_frame('0, 1'b0, fr(25, 25));
`else
        drive_frame('0, 1'b0, fr(10, 10));
        drive_frame('0, 1'b0, fr(20, 20));
`endif
    endtask

    task automatic test_clear_midframe();
        logic [FW-1:0] last;
`ifdef LOOPER_OVERDUB_EN
        last = fr(25, 25);
`else
        last = fr(20, 20);
`endif
        @(negedge clk);
        in_data   = fr(1, 1);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== last)
            $display("FAIL clear_mid: valid=%b data=%h, want 0 %h", out_valid, out_data, last);
        else
            n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (state !== 2'd0 || loop_len !== '0 || full !== 1'b0 || out_data !== last)
            $display("FAIL clear_after: state=%0d len=%0d full=%b data=%h, want 0 0 0 %h",
                     state, loop_len, full, out_data, last);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_reset_midrecord();
        test_record_play();
        test_reverse();
        test_full();
        test_saturation();
        test_overdub();
        test_clear_midframe();
        repeat (4) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d frames never produced, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/audio_looper_mc.md
# audio_looper_mc

Parametrised multi-channel audio looper. Sits between the per-channel filter outputs and the audio CODEC write port. It records a loop of sample frames into on-chip RAM, then plays the loop back mixed with live input, forward or reversed. Optional overdub layers new input onto the stored loop. It generalises the two-instance, fixed-width stereo looper to CH channels, DATA_W bits and 2^ADDR_W frames, driven by one control FSM.

## Interface
Parameters:
- CH, 2, number of audio channels sharing one RAM word and one FSM
- DATA_W, 24, signed two's-complement sample width per channel
- ADDR_W, 15, loop depth is DEPTH = 2^ADDR_W frames

Ports:
- clk  in  1  system clock (CLOCK_50 domain); the block's only clock
- reset  in  1  asynchronous, active-high; clears FSM, pointers and outputs
- sample_en  in  1  one-cycle frame strobe (CODEC write_ready qualified); at least 3 cycles between strobes
- in_data  in  CH*DATA_W  live frame, channel 0 in the LSBs
- rec_pulse  in  1  one-cycle control pulse, already edge-detected by the caller
- clear  in  1  level; returns the block to IDLE and discards the loop
- reverse  in  1  level; 1 selects reversed playback direction
- out_data  out  CH*DATA_W  registered output frame
- out_valid  out  1  one-cycle pulse when out_data updates
- state  out  2  IDLE=0, RECORD=1, PLAY=2, OVERDUB=3
- loop_len  out  ADDR_W+1  number of recorded frames (0..DEPTH)
- full  out  1  high when loop_len == DEPTH

## Operation
- Reset values:
  - state=IDLE
  - out_data=0, out_valid=0
  - loop_len=0, full=0
  - wr/rd pointer=0
- FSM transitions (priority: clear > auto-full > rec_pulse):
  - IDLE --rec_pulse--> RECORD. Pointer=0, loop_len=0.
  - RECORD --rec_pulse--> PLAY if loop_len>0, else IDLE.
  - RECORD --frame written with loop_len reaching DEPTH--> PLAY, same cycle as that write.
  - PLAY --rec_pulse--> OVERDUB (only with LOOPER_OVERDUB_EN).
  - OVERDUB --rec_pulse--> PLAY.
  - Any state --clear--> IDLE. loop_len=0. RAM contents are not erased.
- Entering PLAY: the pointer loads 0 if reverse=0, else loop_len-1.
- Per-state frame behaviour:
  - IDLE: each frame out_data = in_data (pass-through).
  - RECORD: in_data is written at pointer; pointer++; loop_len++; out_data = in_data.
  - PLAY: RAM is read at pointer; out_data = sat_add(in_data, loop) per channel.
  - OVERDUB: as PLAY, and the same saturated sum is also written back to the same address.
- Pointer advance in PLAY/OVERDUB:
  - Forward: wraps loop_len-1 -> 0.
  - Reverse: wraps 0 -> loop_len-1.
  - A change of reverse mid-loop takes effect at the next frame, stepping from the current pointer with no jump.
- sat_add: signed DATA_W+1 sum, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1], per channel independently.
- rec_pulse in the same cycle as sample_en: the frame is processed under the old state; the new state applies from the next frame.

## Timing
- Strobe at cycle t: in_data is captured and the RAM access is issued at t. The synchronous read returns at t+1.
- out_data/out_valid are registered at t+2 in all states. Latency is fixed at 2 cycles, including pass-through.
- OVERDUB write-back happens at t+1. It never collides with a read, given the strobe spacing.
- clear/reset mid-frame: the pending out_valid is suppressed; out_data holds its last value under clear and goes to 0 under reset.

## Configuration
- LOOPER_OVERDUB_EN defined: the OVERDUB state and RAM write-back are compiled in.
- Macro absent: rec_pulse in PLAY is ignored, and only clear leaves PLAY. state never reads 3.

## Structure
- Package looper_pkg holds:
  - the state enum and its encodings
  - the sat_add function, parametrised by DATA_W
- One sub-module, looper_ram: single-port synchronous RAM, CH*DATA_W wide, DEPTH deep, 1-cycle read, inferred as block RAM.
- The FSM, pointer logic and mixer stay in audio_looper_mc.

## Test plan
All scenarios use CH=2, DATA_W=24, ADDR_W=4.
1. Reset asserted mid-RECORD after 5 frames -> state=0, loop_len=0, out_data=0, out_valid=0 immediately (asynchronous).
2. Record frames 1..6, rec_pulse, then play with in_data=0 -> out_data sequence 1,2,3,4,5,6,1,2; out_valid 2 cycles after each strobe.
3. Same loop with reverse=1 asserted after the 3rd playback frame -> playback 1,2,3,2,1,6,5.
4. Record 16 frames without rec_pulse -> full=1, state=PLAY on the 16th write, loop_len=16; a 17th frame is not written.
5. Loop sample 0x7FFFF0 with in_data=0x000100 -> out 0x7FFFFF; loop sample 0x800010 with in_data=0xFFFF00 -> out 0x800000.
6. With LOOPER_OVERDUB_EN: loop {10,20}, overdub one pass with in_data=5, then PLAY with in_data=0 -> out 15,25. Without the macro, rec_pulse in PLAY leaves state=2.
